// File: rtl/ethernet_pkg.sv
// Constants and state encoding shared by the Ethernet RX checker and the TX path.
package ethernet_pkg;

    localparam logic [7:0]  PREAMBLE_BYTE = 8'h55;
    localparam logic [7:0]  SFD_BYTE      = 8'hD5;
    localparam logic [31:0] CRC_POLY      = 32'hEDB88320;
    localparam logic [31:0] CRC_INIT      = 32'hFFFFFFFF;
    localparam logic [31:0] CRC_RESIDUE   = 32'hDEBB20E3;

    localparam int              LEN_W   = 11;
    localparam logic [LEN_W-1:0] LEN_SAT = '1;
    localparam logic [2:0]      PRE_SAT = 3'd7;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_PREAMBLE = 2'd1,
        ST_RECEIVE  = 2'd2,
        ST_DROP     = 2'd3
    } rx_state_e;

endpackage

// File: rtl/ethernet_crc32.sv
// One-byte step of the reflected Ethernet CRC-32, LSB of the byte first.
module ethernet_crc32
    import ethernet_pkg::*;
(
    input  logic [31:0] crc_in,
    input  logic [7:0]  data,
    output logic [31:0] crc_out
);

    logic [8:0][31:0] stage;

    assign stage[0] = crc_in;

    generate
        for (genvar gi = 0; gi < 8; gi++) begin : g_bit
            assign stage[gi+1] = (stage[gi][0] ^ data[gi]) ? ((stage[gi] >> 1) ^ CRC_POLY)
                                                           : (stage[gi] >> 1);
        end
    endgenerate

    assign crc_out = stage[8];

endmodule

// File: rtl/ethernet_rx_frame_checker.sv
// Strips preamble/SFD from the received byte stream, forwards frame bytes and
// reports CRC/length status when the delayed rx_dv drops.
module ethernet_rx_frame_checker
    import ethernet_pkg::*;
#(
    parameter int MIN_LEN  = 64,
    parameter int MAX_LEN  = 1518,
    parameter int DV_DELAY = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [7:0]       byte_i,
    input  logic             byte_ready_i,
    input  logic             rx_dv_i,
    output logic [7:0]       data_out_o,
    output logic             data_valid_o,
    output logic             frame_start_o,
    output logic             frame_end_o,
    output logic             frame_good_o,
    output logic [LEN_W-1:0] frame_length_o
);

    localparam logic [LEN_W-1:0] MIN_LEN_L = LEN_W'(MIN_LEN);
    localparam logic [LEN_W-1:0] MAX_LEN_L = LEN_W'(MAX_LEN);

    rx_state_e        state_q, state_d;
    logic [DV_DELAY-1:0] dv_pipe_q;
    logic             dv_dly;
    logic [2:0]       pre_cnt_q;
    logic [31:0]      crc_q, crc_calc, crc_cur;
    logic [LEN_W-1:0] len_q, len_inc, len_cur;
    logic             first_q;
    logic [7:0]       data_out_q;
    logic             data_valid_q, frame_start_q, frame_end_q, frame_good_q;
    logic [LEN_W-1:0] frame_length_q;

    logic pre_clr, pre_inc, sfd_hit, rx_byte, frame_done, good_now;

    // rx_dv arrives ahead of the aggregated bytes; realign it before any framing decision.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            dv_pipe_q <= '0;
        end else begin
            dv_pipe_q[0] <= rx_dv_i;
            for (int i = 1; i < DV_DELAY; i++) begin
                dv_pipe_q[i] <= dv_pipe_q[i-1];
            end
        end
    end

    assign dv_dly = dv_pipe_q[DV_DELAY-1];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= ST_IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (dv_dly) state_d = ST_PREAMBLE;
            end
            ST_PREAMBLE: begin
                if (!dv_dly) begin
                    state_d = ST_IDLE;
                end else if (byte_ready_i) begin
                    if (byte_i == PREAMBLE_BYTE)                        state_d = ST_PREAMBLE;
                    else if (byte_i == SFD_BYTE && pre_cnt_q != 3'd0)   state_d = ST_RECEIVE;
                    else                                                state_d = ST_DROP;
                end
            end
            ST_RECEIVE: begin
                if (!dv_dly) state_d = ST_IDLE;
            end
            ST_DROP: begin
                if (!dv_dly) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        pre_clr    = (state_q == ST_IDLE);
        pre_inc    = (state_q == ST_PREAMBLE) && dv_dly && byte_ready_i && (byte_i == PREAMBLE_BYTE);
        sfd_hit    = (state_q == ST_PREAMBLE) && dv_dly && byte_ready_i && (byte_i == SFD_BYTE)
                     && (pre_cnt_q != 3'd0);
        rx_byte    = (state_q == ST_RECEIVE) && byte_ready_i;
        frame_done = (state_q == ST_RECEIVE) && !dv_dly;
    end

    ethernet_crc32 u_crc (
        .crc_in  (crc_q),
        .data    (byte_i),
        .crc_out (crc_calc)
    );

    // A byte landing on the same cycle dv drops must still count toward the status.
    assign len_inc  = (len_q == LEN_SAT) ? len_q : len_q + 1'b1;
    assign crc_cur  = rx_byte ? crc_calc : crc_q;
    assign len_cur  = rx_byte ? len_inc  : len_q;
    assign good_now = (crc_cur == CRC_RESIDUE) && (len_cur >= MIN_LEN_L) && (len_cur <= MAX_LEN_L);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pre_cnt_q      <= 3'd0;
            crc_q          <= CRC_INIT;
            len_q          <= '0;
            first_q        <= 1'b0;
            data_out_q     <= 8'd0;
            data_valid_q   <= 1'b0;
            frame_start_q  <= 1'b0;
            frame_end_q    <= 1'b0;
            frame_good_q   <= 1'b0;
            frame_length_q <= '0;
        end else begin
            if (pre_clr)                           pre_cnt_q <= 3'd0;
            else if (pre_inc && pre_cnt_q != PRE_SAT) pre_cnt_q <= pre_cnt_q + 3'd1;

            if (sfd_hit) begin
                crc_q   <= CRC_INIT;
                len_q   <= '0;
                first_q <= 1'b1;
            end else if (rx_byte) begin
                crc_q   <= crc_calc;
                len_q   <= len_inc;
                first_q <= 1'b0;
            end

            data_valid_q  <= rx_byte;
            frame_start_q <= rx_byte && first_q;
            if (rx_byte) data_out_q <= byte_i;

            frame_end_q <= frame_done;
            if (frame_done) begin
                frame_good_q   <= good_now;
                frame_length_q <= len_cur;
            end
        end
    end

    assign data_out_o     = data_out_q;
    assign data_valid_o   = data_valid_q;
    assign frame_start_o  = frame_start_q;
    assign frame_end_o    = frame_end_q;
    assign frame_good_o   = frame_good_q;
    assign frame_length_o = frame_length_q;

endmodule

// File: doc/ethernet_rx_frame_checker.md
ETHERNET_RX_FRAME_CHECKER -- requirements
Module: ethernet_rx_frame_checker

Interface
REQ-001 SHALL have parameter MIN_LEN, default 64, minimum good frame length in bytes after SFD, FCS included.
REQ-002 SHALL have parameter MAX_LEN, default 1518, maximum good frame length in bytes after SFD, FCS included.
REQ-003 SHALL have parameter DV_DELAY, default 2, clocks of rx_dv delay that align it with the byte stream.
REQ-004 clk  input  1  clock; all logic on rising edge.
REQ-005 reset  input  1  reset, asynchronous, active-high.
REQ-006 byte  input  8  received byte from the upstream nibble aggregator, low nibble first on wire.
REQ-007 byte_ready  input  1  single-cycle pulse; byte valid this cycle.
REQ-008 rx_dv  input  1  MII receive-data-valid level, undelayed.
REQ-009 data_out  output  8  frame byte after SFD, FCS included.
REQ-010 data_valid  output  1  single-cycle pulse; data_out valid.
REQ-011 frame_start  output  1  pulse coincident with data_valid of first post-SFD byte.
REQ-012 frame_end  output  1  single-cycle pulse; frame finished, status valid.
REQ-013 frame_good  output  1  status: CRC correct and length within limits; held until next frame_end.
REQ-014 frame_length  output  11  post-SFD byte count, saturating at 2047; held until next frame_end.

Function
REQ-015 SHALL delay rx_dv by DV_DELAY registers to form dv_d; all frame boundaries SHALL use dv_d.
REQ-016 SHALL implement FSM states IDLE, PREAMBLE, RECEIVE, DROP.
REQ-017 IDLE: dv_d high -> PREAMBLE; preamble count cleared.
REQ-018 PREAMBLE: byte_ready with 0x55 -> stay, increment preamble count (saturating at 7).
REQ-019 PREAMBLE: byte_ready with 0xD5 and preamble count >= 1 -> RECEIVE; CRC register loaded with 0xFFFFFFFF; length cleared.
REQ-020 PREAMBLE: any other byte, or 0xD5 with count 0 -> DROP.
REQ-021 PREAMBLE or DROP: dv_d low -> IDLE, with no frame_end and no data_valid.
REQ-022 RECEIVE: each byte_ready -> CRC update, length increment (saturating), data_out/data_valid registered one clock later.
REQ-023 RECEIVE: dv_d low -> IDLE; frame_end asserted one clock later with frame_good and frame_length updated in the same cycle.
REQ-024 If byte_ready coincides with dv_d falling, the byte SHALL be included in CRC, length and output before frame_end.
REQ-025 CRC: reflected CRC-32, polynomial 0xEDB88320, LSB-first, one byte per clock, no final XOR inside the register.
REQ-026 frame_good = (CRC register == 0xDEBB20E3 after the last byte) AND MIN_LEN <= length <= MAX_LEN.
REQ-027 Oversize frames SHALL still be forwarded byte-for-byte, and frame_good SHALL be 0.
REQ-028 A frame with zero post-SFD bytes SHALL produce frame_end with frame_good 0 and frame_length 0.
REQ-029 byte_ready in IDLE or DROP SHALL be ignored.

Reset
REQ-030 Reset SHALL force IDLE, dv_d pipeline 0, CRC 0xFFFFFFFF, length 0, and preamble count 0.
REQ-031 Reset SHALL set all outputs to 0, including data_out, frame_good and frame_length.
REQ-032 Reset mid-frame SHALL discard the frame: no frame_end; the next frame SHALL need a fresh preamble and SFD.

Structure
REQ-033 Shared package ethernet_pkg SHALL hold PREAMBLE_BYTE 0x55, SFD_BYTE 0xD5, CRC_POLY 0xEDB88320, CRC_INIT 0xFFFFFFFF, CRC_RESIDUE 0xDEBB20E3, and the FSM state encoding.
REQ-034 The CRC update SHALL be a combinational sub-module ethernet_crc32 (crc_in[31:0], data[7:0] -> crc_out[31:0]), reusable by the TX path.

Verification
REQ-035 7x0x55, 0xD5, 60 payload bytes, then correct FCS (4 bytes LSB-first) -> 64 data_valid, frame_start on first, frame_end, frame_good=1, frame_length=64.
REQ-036 Same frame with payload byte 10 XOR 0x01 -> frame_end, frame_good=0, frame_length=64.
REQ-037 56 payload bytes with valid FCS (60 total) -> frame_good=0, frame_length=60.
REQ-038 Preamble 0x55,0x55,0x5D then 70 bytes -> no data_valid, no frame_start, no frame_end.
REQ-039 1600-byte frame with valid FCS -> 1600 data_valid, frame_good=0, frame_length=1600.
REQ-040 Reset asserted after 20 post-SFD bytes, then released, then a good 64-byte frame -> no frame_end for the aborted frame; the second frame reports frame_good=1, frame_length=64.
